// File: rtl/ddr_app_responder.sv
// Behavioural DDR UI responder: queued commands and write beats, in-order execution, fixed read latency.
// Optional DDR_RESP_STALL_EN adds pseudo-random ready stalls from a 16-bit LFSR.
module ddr_app_responder #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 512,
  parameter int DEPTH_LOG2   = 10,
  parameter int ADDR_LSB     = 3,
  parameter int RD_LATENCY   = 8,
  parameter int CALIB_CYCLES = 64,
  parameter int Q_DEPTH      = 4
) (
  input  logic                core_clk,
  input  logic                sys_rst,
  output logic                init_calib_complete,
  input  logic                app_en,
  input  logic [2:0]          app_cmd,
  input  logic [ADDR_W-1:0]   app_addr,
  output logic                app_rdy,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end
);

  localparam int MASK_W = DATA_W / 8;
  localparam int WORDS  = 1 << DEPTH_LOG2;
  localparam int QW     = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW     = (CALIB_CYCLES > 0) ? $clog2(CALIB_CYCLES + 1) : 1;
  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  logic [CW-1:0]         cal_cnt_r;
  logic                  calib_r;
  logic                  calib_next_s;
  logic                  app_rdy_r;
  logic                  wdf_rdy_r;

  logic [2:0]            cq_cmd_r [Q_DEPTH];
  logic [DEPTH_LOG2-1:0] cq_idx_r [Q_DEPTH];
  logic [QW-1:0]         cq_wp_r;
  logic [QW-1:0]         cq_rp_r;
  logic [QW:0]           cq_cnt_r;
  logic [QW:0]           cq_cnt_next_s;

  logic [DATA_W-1:0]     wq_data_r [Q_DEPTH];
  logic [MASK_W-1:0]     wq_mask_r [Q_DEPTH];
  logic [QW-1:0]         wq_wp_r;
  logic [QW-1:0]         wq_rp_r;
  logic [QW:0]           wq_cnt_r;
  logic [QW:0]           wq_cnt_next_s;

  // Storage starts at zero and is deliberately never cleared by reset.
  logic [DATA_W-1:0]     mem_r [WORDS] = '{default: '0};

  logic [RD_LATENCY-1:0] rd_vld_r;
  logic [DATA_W-1:0]     rd_dat_r [RD_LATENCY];

  logic                  cmd_push_s;
  logic                  wdf_push_s;
  logic                  cmd_pop_s;
  logic                  wdf_pop_s;
  logic                  mem_we_s;
  logic                  rd_issue_s;
  logic                  stall_s;
  logic [2:0]            head_cmd_s;
  logic [DEPTH_LOG2-1:0] head_idx_s;
  logic [DEPTH_LOG2-1:0] push_idx_s;
  logic [DATA_W-1:0]     rd_word_s;
  logic                  unused_s;

`ifdef DDR_RESP_STALL_EN
  logic [15:0]           lfsr_r;
  logic [15:0]           lfsr_next_s;
`endif

  assign unused_s   = ^{app_wdf_end, app_addr};
  assign push_idx_s = app_addr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB];
  assign cmd_push_s = app_en && app_rdy_r;
  assign wdf_push_s = app_wdf_wren && wdf_rdy_r;
  assign head_cmd_s = cq_cmd_r[cq_rp_r];
  assign head_idx_s = cq_idx_r[cq_rp_r];
  assign rd_word_s  = mem_r[head_idx_s];

  // Head-of-queue execution: a write waits for its beat, everything else retires immediately.
  always_comb begin
    cmd_pop_s  = 1'b0;
    wdf_pop_s  = 1'b0;
    mem_we_s   = 1'b0;
    rd_issue_s = 1'b0;
    if (cq_cnt_r != '0) begin
      case (head_cmd_s)
        CMD_WR: begin
          if (wq_cnt_r != '0) begin
            cmd_pop_s = 1'b1;
            wdf_pop_s = 1'b1;
            mem_we_s  = 1'b1;
          end else begin
            cmd_pop_s = 1'b0;
            wdf_pop_s = 1'b0;
            mem_we_s  = 1'b0;
          end
        end
        CMD_RD: begin
          cmd_pop_s  = 1'b1;
          rd_issue_s = 1'b1;
        end
        default: begin
          cmd_pop_s = 1'b1;
        end
      endcase
    end else begin
      cmd_pop_s = 1'b0;
    end
  end

  // Next-state values for calibration, queue occupancy and ready gating.
  always_comb begin
    cq_cnt_next_s = cq_cnt_r + {{QW{1'b0}}, cmd_push_s} - {{QW{1'b0}}, cmd_pop_s};
    wq_cnt_next_s = wq_cnt_r + {{QW{1'b0}}, wdf_push_s} - {{QW{1'b0}}, wdf_pop_s};
    if (calib_r) begin
      calib_next_s = 1'b1;
    end else if (cal_cnt_r == CW'(CALIB_CYCLES - 1)) begin
      calib_next_s = 1'b1;
    end else begin
      calib_next_s = 1'b0;
    end
`ifdef DDR_RESP_STALL_EN
    lfsr_next_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    stall_s     = (lfsr_next_s[1:0] == 2'b00);
`else
    stall_s     = 1'b0;
`endif
  end

`ifdef DDR_RESP_STALL_EN
  // Stall pattern generator.
  always_ff @(posedge core_clk) begin
    if (sys_rst) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= lfsr_next_s;
    end
  end
`endif

  // Calibration counter and ready flags; ready is registered from next-cycle occupancy.
  always_ff @(posedge core_clk) begin
    if (sys_rst) begin
      cal_cnt_r <= '0;
      calib_r   <= 1'b0;
      app_rdy_r <= 1'b0;
      wdf_rdy_r <= 1'b0;
    end else begin
      calib_r   <= calib_next_s;
      if (!calib_r) begin
        cal_cnt_r <= cal_cnt_r + CW'(1);
      end
      app_rdy_r <= calib_next_s && (cq_cnt_next_s < (QW+1)'(Q_DEPTH)) && !stall_s;
      wdf_rdy_r <= calib_next_s && (wq_cnt_next_s < (QW+1)'(Q_DEPTH)) && !stall_s;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge core_clk) begin
    if (sys_rst) begin
      cq_wp_r  <= '0;
      cq_rp_r  <= '0;
      cq_cnt_r <= '0;
      wq_wp_r  <= '0;
      wq_rp_r  <= '0;
      wq_cnt_r <= '0;
    end else begin
      cq_cnt_r <= cq_cnt_next_s;
      wq_cnt_r <= wq_cnt_next_s;
      if (cmd_push_s) cq_wp_r <= cq_wp_r + QW'(1);
      if (cmd_pop_s)  cq_rp_r <= cq_rp_r + QW'(1);
      if (wdf_push_s) wq_wp_r <= wq_wp_r + QW'(1);
      if (wdf_pop_s)  wq_rp_r <= wq_rp_r + QW'(1);
    end
  end

  // Queue entry storage; stale entries after a flush are unreachable.
  always_ff @(posedge core_clk) begin
    if (cmd_push_s) begin
      cq_cmd_r[cq_wp_r] <= app_cmd;
      cq_idx_r[cq_wp_r] <= push_idx_s;
    end
    if (wdf_push_s) begin
      wq_data_r[wq_wp_r] <= app_wdf_data;
      wq_mask_r[wq_wp_r] <= app_wdf_mask;
    end
  end

  // Byte-masked word update; a set mask bit leaves that byte untouched.
  always_ff @(posedge core_clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wq_mask_r[wq_rp_r][b]) begin
          mem_r[head_idx_s][b*8 +: 8] <= wq_data_r[wq_rp_r][b*8 +: 8];
        end
      end
    end
  end

  // Read return pipeline; data is zero in every stage that carries no read.
  always_ff @(posedge core_clk) begin
    if (sys_rst) begin
      rd_vld_r <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_dat_r[i] <= '0;
      end
    end else begin
      rd_vld_r[0] <= rd_issue_s;
      rd_dat_r[0] <= rd_issue_s ? rd_word_s : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_r[i] <= rd_vld_r[i-1];
        rd_dat_r[i] <= rd_dat_r[i-1];
      end
    end
  end

  assign init_calib_complete = calib_r;
  assign app_rdy             = app_rdy_r;
  assign app_wdf_rdy         = wdf_rdy_r;
  assign app_rd_data         = rd_dat_r[RD_LATENCY-1];
  assign app_rd_data_valid   = rd_vld_r[RD_LATENCY-1];
  assign app_rd_data_end     = rd_vld_r[RD_LATENCY-1];

endmodule

// File: tb/tb_ddr_app_responder.sv
// Scoreboard bench for ddr_app_responder: directed scenarios plus randomized traffic
// against a transaction-level memory model.
module tb_ddr_app_responder;

  localparam int DW    = 512;
  localparam int MW    = DW / 8;
  localparam int LAT   = 8;
  localparam int CAL   = 64;
  localparam int BOUND = 300;

  logic          core_clk = 1'b0;
  logic          sys_rst;
  logic          init_calib_complete;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [27:0]   app_addr;
  logic          app_rdy;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;

  ddr_app_responder dut (
    .core_clk(core_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end)
  );

  always #5 core_clk = ~core_clk;

  typedef struct { logic [2:0] cmd; int idx; int acc; bit lat; } pend_t;
  typedef struct { logic [DW-1:0] d; logic [MW-1:0] m; } beat_t;
  typedef struct { logic [DW-1:0] d; int acc; bit lat; } exp_t;

  logic [DW-1:0] ref_mem [1024];
  pend_t pend_q[$];
  beat_t beat_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always @(posedge core_clk) cyc++;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic int widx(input logic [27:0] a);
    return (int'(a) / 8) % 1024;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Executes model commands in acceptance order; a write needs an accepted beat.
  task automatic drain();
    pend_t c;
    beat_t bt;
    exp_t  e;
    while (pend_q.size() > 0) begin
      c = pend_q[0];
      if (c.cmd == 3'd0) begin
        if (beat_q.size() == 0) break;
        bt = beat_q.pop_front();
        for (int b = 0; b < MW; b++)
          if (!bt.m[b]) ref_mem[c.idx][b*8 +: 8] = bt.d[b*8 +: 8];
      end else if (c.cmd == 3'd1) begin
        e.d = ref_mem[c.idx];
        e.acc = c.acc;
        e.lat = c.lat;
        exp_q.push_back(e);
      end
      void'(pend_q.pop_front());
    end
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [27:0] a, input bit lat);
    int t = 0;
    pend_t p;
    app_en = 1'b1; app_cmd = c; app_addr = a;
    while (!app_rdy && t < BOUND) begin
      @(negedge core_clk);
      t++;
    end
    chk("cmd_accept", {511'd0, app_rdy}, {511'd0, 1'b1});
    if (app_rdy) begin
      p.cmd = c; p.idx = widx(a); p.acc = cyc + 1; p.lat = lat;
      pend_q.push_back(p);
      drain();
      @(negedge core_clk);
    end
    app_en = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [MW-1:0] m);
    int t = 0;
    beat_t bt;
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    while (!app_wdf_rdy && t < BOUND) begin
      @(negedge core_clk);
      t++;
    end
    chk("beat_accept", {511'd0, app_wdf_rdy}, {511'd0, 1'b1});
    if (app_wdf_rdy) begin
      bt.d = d; bt.m = m;
      beat_q.push_back(bt);
      drain();
      @(negedge core_clk);
    end
    app_wdf_wren = 1'b0;
  endtask

  task automatic write(input logic [27:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    fork
      send_cmd(3'd0, a, 1'b0);
      send_beat(d, m);
    join
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && t < 2000) begin
      @(negedge core_clk);
      t++;
    end
    chk("drain_idle", {480'd0, 32'(exp_q.size() + pend_q.size())}, '0);
    repeat (12) @(negedge core_clk);
  endtask

  // Resets the DUT and model queues, then checks the calibration window edge by edge.
  task automatic do_reset();
    @(negedge core_clk);
    sys_rst = 1'b1; app_en = 1'b0; app_wdf_wren = 1'b0;
    exp_q.delete(); pend_q.delete(); beat_q.delete();
    repeat (3) begin
      @(negedge core_clk);
      chk("rst_calib", {511'd0, init_calib_complete}, '0);
      chk("rst_app_rdy", {511'd0, app_rdy}, '0);
      chk("rst_wdf_rdy", {511'd0, app_wdf_rdy}, '0);
      chk("rst_rd_valid", {511'd0, app_rd_data_valid}, '0);
      chk("rst_rd_end", {511'd0, app_rd_data_end}, '0);
      chk("rst_rd_data", app_rd_data, '0);
    end
    sys_rst = 1'b0;
    for (int i = 1; i <= CAL; i++) begin
      @(negedge core_clk);
      chk("calib_edge", {511'd0, init_calib_complete}, {511'd0, i >= CAL});
      chk("calib_app_rdy", {511'd0, app_rdy}, {511'd0, i >= CAL});
      chk("calib_wdf_rdy", {511'd0, app_wdf_rdy}, {511'd0, i >= CAL});
    end
  endtask

  // Monitor: every read return is matched against the oldest expected read.
  always @(negedge core_clk) begin
    exp_t e;
    if (app_rd_data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got valid=1 data %h required no read pending", app_rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", app_rd_data, e.d);
        chk("rd_end", {511'd0, app_rd_data_end}, {511'd0, 1'b1});
        if (e.lat) chk("rd_latency", DW'(cyc - e.acc), DW'(LAT));
      end
    end else if (!sys_rst) begin
      chk("idle_rd_data", app_rd_data, '0);
      chk("idle_rd_end", {511'd0, app_rd_data_end}, '0);
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got no completion required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [27:0]   a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    int            r;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    sys_rst = 1'b1; app_en = 1'b0; app_cmd = 3'd0; app_addr = '0;
    app_wdf_wren = 1'b0; app_wdf_end = 1'b1; app_wdf_data = '0; app_wdf_mask = '0;
    do_reset();

    // Basic write then read with latency check.
    d = {64{8'hA5}};
    write(28'h40, d, '0);
    send_cmd(3'd1, 28'h40, 1'b1);
    wait_idle();

    // Masked write: only byte 0 written.
    write(28'h80, {DW{1'b1}}, '0);
    m = '1; m[0] = 1'b0;
    write(28'h80, '0, m);
    send_cmd(3'd1, 28'h80, 1'b0);
    wait_idle();

    // Command queue fills behind a write that has no data yet.
    send_cmd(3'd0, 28'h200, 1'b0);
    send_cmd(3'd1, 28'h200, 1'b0);
    send_cmd(3'd1, 28'h40, 1'b0);
    send_cmd(3'd1, 28'h80, 1'b0);
    repeat (3) begin
      chk("full_app_rdy", {511'd0, app_rdy}, '0);
      @(negedge core_clk);
    end
    fork
      send_cmd(3'd1, 28'h200, 1'b0);
      send_beat({16{32'h1234_5678}}, '0);
    join
    wait_idle();

    // Address aliasing above the word index.
    write(28'h40 + 28'(1 << 13), {16{32'hDEAD_BEEF}}, '0);
    send_cmd(3'd1, 28'h40, 1'b0);
    wait_idle();

    // Beat accepted long before its command.
    send_beat({8{64'h0F0F_F0F0_1111_2222}}, '0);
    repeat (20) @(negedge core_clk);
    send_cmd(3'd0, 28'h100, 1'b0);
    send_cmd(3'd1, 28'h100, 1'b0);
    wait_idle();

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      a = 28'(($urandom_range(0, 31) << 3) | $urandom_range(0, 7) | ($urandom_range(0, 3) << 13));
      d = rnd_word();
      r = $urandom_range(0, 3);
      m = (r == 0) ? '0 : (r == 1) ? '1 : MW'({$urandom(), $urandom()});
      r = $urandom_range(0, 11);
      if (r < 4) begin
        write(a, d, m);
      end else if (r < 8) begin
        send_cmd(3'd1, a, 1'b0);
      end else if (r < 10) begin
        send_cmd(3'($urandom_range(2, 7)), a, 1'b0);
      end else if (r == 10) begin
        send_cmd(3'd0, a, 1'b0);
        repeat ($urandom_range(0, 2)) send_cmd(3'd1, a, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge core_clk);
        send_beat(d, m);
      end else begin
        send_beat(d, m);
        repeat ($urandom_range(0, 4)) @(negedge core_clk);
        send_cmd(3'd0, a, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) @(negedge core_clk);
    end
    wait_idle();

    // Reset with reads in flight and an orphan beat queued.
    send_beat({DW{1'b1}}, '0);
    send_cmd(3'd1, 28'h40, 1'b0);
    send_cmd(3'd1, 28'h80, 1'b0);
    send_cmd(3'd1, 28'h100, 1'b0);
    @(negedge core_clk);
    do_reset();
    repeat (12) @(negedge core_clk);
    write(28'h40, {32{16'hC3C3}}, '0);
    send_cmd(3'd1, 28'h40, 1'b1);
    send_cmd(3'd1, 28'h80, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
